// File: rtl/y86_pkg.sv
// Shared Y86-64 constants, the architectural reset table and the E-stage control struct.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic       valid;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } e_ctrl_t;

  localparam e_ctrl_t E_CTRL_NOP = '{valid: 1'b0, icode: I_NOP, ifun: 4'h0,
                                     src_a: RNONE, src_b: RNONE,
                                     dst_e: RNONE, dst_m: RNONE};

  // Signed so callers sign-extend when DATA_W exceeds 64.
  function automatic logic signed [63:0] reset_val(input logic [3:0] idx);
    case (idx)
      4'd0:    return 64'sd111;
      4'd1:    return 64'sd222;
      4'd2:    return 64'sd333;
      4'd3:    return 64'sd444;
      4'd4:    return 64'sd555;
      4'd5:    return 64'sd666;
      4'd6:    return -64'sd777;
      4'd7:    return 64'sd888;
      4'd8:    return 64'sd999;
      4'd9:    return -64'sd1111;
      4'd10:   return 64'sd2222;
      4'd11:   return 64'sd3333;
      4'd12:   return 64'sd4444;
      4'd13:   return 64'sd5555;
      4'd14:   return 64'sd6666;
      default: return 64'sd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86 register array: two write ports (M beats E on collision), three read ports.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        w_dst_e,
  input  logic [3:0]        w_dst_m,
  input  logic [DATA_W-1:0] w_val_e,
  input  logic [DATA_W-1:0] w_val_m,
  input  logic [3:0]        rd_a_idx,
  input  logic [3:0]        rd_b_idx,
  input  logic [3:0]        rd_dbg_idx,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] rd_dbg
);

  // Index 15 is RNONE and must never be backed by storage.
  localparam int N_IMPL = (NREGS > 15) ? 15 : NREGS;

  logic [DATA_W-1:0] regs [N_IMPL];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IMPL; i++) regs[i] <= DATA_W'(reset_val(4'(i)));
    end else begin
      for (int i = 0; i < N_IMPL; i++) begin
        if (w_dst_m == 4'(i))      regs[i] <= w_val_m;
        else if (w_dst_e == 4'(i)) regs[i] <= w_val_e;
      end
    end
  end

  always_comb begin
    rd_a   = '0;
    rd_b   = '0;
    rd_dbg = '0;
    for (int i = 0; i < N_IMPL; i++) begin
      if (rd_a_idx == 4'(i))   rd_a   = regs[i];
      if (rd_b_idx == 4'(i))   rd_b   = regs[i];
      if (rd_dbg_idx == 4'(i)) rd_dbg = regs[i];
    end
  end

endmodule

// File: rtl/y86_decode_regfile.sv
// Y86-64 decode stage: source/destination decode, register read with optional
// write-back forwarding, and the D->E pipeline register with stall/bubble.
module y86_decode_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_rA,
  input  logic [3:0]        d_rB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valP,
  input  logic              stall,
  input  logic              bubble,
  input  logic [3:0]        w_dstE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [DATA_W-1:0] w_valM,
  output logic              e_valid,
  output logic [3:0]        e_icode,
  output logic [3:0]        e_ifun,
  output logic [DATA_W-1:0] e_valC,
  output logic [DATA_W-1:0] e_valA,
  output logic [DATA_W-1:0] e_valB,
  output logic [3:0]        e_srcA,
  output logic [3:0]        e_srcB,
  output logic [3:0]        e_dstE,
  output logic [3:0]        e_dstM,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  e_ctrl_t           e_ctrl;
  logic [DATA_W-1:0] e_val_c_q, e_val_a_q, e_val_b_q;

  y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_dst_e    (w_dstE),
    .w_dst_m    (w_dstM),
    .w_val_e    (w_valE),
    .w_val_m    (w_valM),
    .rd_a_idx   (src_a),
    .rd_b_idx   (src_b),
    .rd_dbg_idx (dbg_sel),
    .rd_a       (rf_a),
    .rd_b       (rf_b),
    .rd_dbg     (dbg_val)
  );

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_icode)
      I_RRMOVQ: begin src_a = d_rA; dst_e = d_rB; end
      I_IRMOVQ: dst_e = d_rB;
      I_RMMOVQ: begin src_a = d_rA; src_b = d_rB; end
      I_MRMOVQ: begin src_b = d_rB; dst_m = d_rA; end
      I_OPQ:    begin src_a = d_rA; src_b = d_rB; dst_e = d_rB; end
      I_CALL:   begin src_b = RSP;  dst_e = RSP; end
      I_RET:    begin src_a = RSP;  src_b = RSP; dst_e = RSP; end
      I_PUSHQ:  begin src_a = d_rA; src_b = RSP; dst_e = RSP; end
      I_POPQ:   begin src_a = RSP;  src_b = RSP; dst_e = RSP; dst_m = d_rA; end
      default:  ;
    endcase
  end

  // Forwarding only applies to implemented registers so RNONE/out-of-range stay 0.
  function automatic logic [DATA_W-1:0] fwd(input logic [3:0]        idx,
                                            input logic [DATA_W-1:0] arr_val);
    logic ok;
    ok = (BYPASS != 0) && (idx != RNONE) && (int'(idx) < NREGS);
    if (ok && idx == w_dstM)      return w_valM;
    else if (ok && idx == w_dstE) return w_valE;
    else                          return arr_val;
  endfunction

  always_comb begin
    val_b = fwd(src_b, rf_b);
    if (d_icode == I_CALL || d_icode == I_JXX) val_a = d_valP;
    else                                       val_a = fwd(src_a, rf_a);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      e_ctrl    <= E_CTRL_NOP;
      e_val_c_q <= '0;
      e_val_a_q <= '0;
      e_val_b_q <= '0;
    end else if (!stall) begin
      e_ctrl    <= '{valid: d_valid, icode: d_icode, ifun: d_ifun,
                     src_a: src_a, src_b: src_b, dst_e: dst_e, dst_m: dst_m};
      e_val_c_q <= d_valC;
      e_val_a_q <= val_a;
      e_val_b_q <= val_b;
    end
  end

  assign e_valid = e_ctrl.valid;
  assign e_icode = e_ctrl.icode;
  assign e_ifun  = e_ctrl.ifun;
  assign e_srcA  = e_ctrl.src_a;
  assign e_srcB  = e_ctrl.src_b;
  assign e_dstE  = e_ctrl.dst_e;
  assign e_dstM  = e_ctrl.dst_m;
  assign e_valC  = e_val_c_q;
  assign e_valA  = e_val_a_q;
  assign e_valB  = e_val_b_q;

endmodule

// File: tb/tb_y86_decode_regfile.sv
// Scoreboard bench: two instances (forwarding on / off) share stimulus; a reference
// model pushes the expected E contents each cycle and they are popped after the edge.
module tb_y86_decode_regfile;

  logic        clk = 1'b0;
  logic        rst_n, d_valid, stall, bubble;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB, w_dstE, w_dstM, dbg_sel;
  logic [63:0] d_valC, d_valP, w_valE, w_valM;

  logic        e_valid_a, e_valid_b;
  logic [3:0]  e_icode_a, e_ifun_a, e_srcA_a, e_srcB_a, e_dstE_a, e_dstM_a;
  logic [3:0]  e_icode_b, e_ifun_b, e_srcA_b, e_srcB_b, e_dstE_b, e_dstM_b;
  logic [63:0] e_valC_a, e_valA_a, e_valB_a, dbg_val_a;
  logic [63:0] e_valC_b, e_valA_b, e_valB_b, dbg_val_b;

  always #10 clk = ~clk;

  y86_decode_regfile #(.DATA_W(64), .NREGS(15), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP), .stall(stall),
    .bubble(bubble), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
    .e_valid(e_valid_a), .e_icode(e_icode_a), .e_ifun(e_ifun_a), .e_valC(e_valC_a),
    .e_valA(e_valA_a), .e_valB(e_valB_a), .e_srcA(e_srcA_a), .e_srcB(e_srcB_a),
    .e_dstE(e_dstE_a), .e_dstM(e_dstM_a), .dbg_sel(dbg_sel), .dbg_val(dbg_val_a));

  y86_decode_regfile #(.DATA_W(64), .NREGS(15), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP), .stall(stall),
    .bubble(bubble), .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
    .e_valid(e_valid_b), .e_icode(e_icode_b), .e_ifun(e_ifun_b), .e_valC(e_valC_b),
    .e_valA(e_valA_b), .e_valB(e_valB_b), .e_srcA(e_srcA_b), .e_srcB(e_srcB_b),
    .e_dstE(e_dstE_b), .e_dstM(e_dstM_b), .dbg_sel(dbg_sel), .dbg_val(dbg_val_b));

  typedef struct {
    logic        valid;
    logic [3:0]  icode, ifun, src_a, src_b, dst_e, dst_m;
    logic [63:0] val_c, val_a, val_b, val_a_nb, val_b_nb;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mdl;
  logic [63:0] mdl [15];
  logic [63:0] rst_tab [15] = '{64'd111, 64'd222, 64'd333, 64'd444, 64'd555, 64'd666,
                                -64'sd777, 64'd888, 64'd999, -64'sd1111, 64'd2222,
                                64'd3333, 64'd4444, 64'd5555, 64'd6666};
  int          n_chk = 0, n_pass = 0;
  string       phase = "init";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, expv);
  endtask

  function automatic logic [63:0] rd(input logic [3:0] idx, input bit byp);
    if (idx == 4'hF) return 64'd0;
    if (byp && idx == w_dstM) return w_valM;
    if (byp && idx == w_dstE) return w_valE;
    return mdl[idx];
  endfunction

  function automatic exp_t nop_exp();
    exp_t n;
    n = '{valid: 1'b0, icode: 4'h1, ifun: 4'h0, src_a: 4'hF, src_b: 4'hF, dst_e: 4'hF,
          dst_m: 4'hF, val_c: 64'd0, val_a: 64'd0, val_b: 64'd0, val_a_nb: 64'd0,
          val_b_nb: 64'd0};
    return n;
  endfunction

  task automatic cyc();
    exp_t       nx, ex;
    logic [3:0] sa, sb, de, dm;
    sa = 4'hF; sb = 4'hF; de = 4'hF; dm = 4'hF;
    case (d_icode)
      4'h2: begin sa = d_rA; de = d_rB; end
      4'h3: de = d_rB;
      4'h4: begin sa = d_rA; sb = d_rB; end
      4'h5: begin sb = d_rB; dm = d_rA; end
      4'h6: begin sa = d_rA; sb = d_rB; de = d_rB; end
      4'h8: begin sb = 4'h4; de = 4'h4; end
      4'h9: begin sa = 4'h4; sb = 4'h4; de = 4'h4; end
      4'hA: begin sa = d_rA; sb = 4'h4; de = 4'h4; end
      4'hB: begin sa = 4'h4; sb = 4'h4; de = 4'h4; dm = d_rA; end
      default: ;
    endcase
    nx = e_mdl;
    if (!rst_n || bubble) nx = nop_exp();
    else if (!stall) begin
      nx.valid = d_valid; nx.icode = d_icode; nx.ifun = d_ifun;
      nx.src_a = sa; nx.src_b = sb; nx.dst_e = de; nx.dst_m = dm; nx.val_c = d_valC;
      nx.val_b = rd(sb, 1'b1); nx.val_b_nb = rd(sb, 1'b0);
      if (d_icode == 4'h8 || d_icode == 4'h7) begin
        nx.val_a = d_valP; nx.val_a_nb = d_valP;
      end else begin
        nx.val_a = rd(sa, 1'b1); nx.val_a_nb = rd(sa, 1'b0);
      end
    end
    exp_q.push_back(nx);
    e_mdl = nx;
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) mdl[i] = rst_tab[i];
    end else begin
      if (w_dstE != 4'hF) mdl[w_dstE] = w_valE;
      if (w_dstM != 4'hF) mdl[w_dstM] = w_valM;
    end
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    chk("valid", e_valid_a, ex.valid);
    chk("icode", e_icode_a, ex.icode);
    chk("ifun",  e_ifun_a,  ex.ifun);
    chk("srcA",  e_srcA_a,  ex.src_a);
    chk("srcB",  e_srcB_a,  ex.src_b);
    chk("dstE",  e_dstE_a,  ex.dst_e);
    chk("dstM",  e_dstM_a,  ex.dst_m);
    chk("valC",  e_valC_a,  ex.val_c);
    chk("valA",  e_valA_a,  ex.val_a);
    chk("valB",  e_valB_a,  ex.val_b);
    chk("nb_valid", e_valid_b, ex.valid);
    chk("nb_valA",  e_valA_b,  ex.val_a_nb);
    chk("nb_valB",  e_valB_b,  ex.val_b_nb);
  endtask

  task automatic peek(input logic [3:0] idx, input logic [63:0] expv);
    dbg_sel = idx;
    #1;
    chk("dbg", dbg_val_a, expv);
    chk("nb_dbg", dbg_val_b, expv);
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vp);
    d_valid = 1'b1; d_icode = ic; d_ifun = 4'h0; d_rA = ra; d_rB = rb;
    d_valC = 64'h0; d_valP = vp;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; bubble = 1'b0;
    d_valid = 1'b1; d_icode = 4'h6; d_ifun = 4'h0; d_rA = 4'h0; d_rB = 4'h1;
    d_valC = 64'h55; d_valP = 64'h66;
    w_dstE = 4'h0; w_valE = 64'h77; w_dstM = 4'h1; w_valM = 64'h88;
    dbg_sel = 4'h0;
    e_mdl = nop_exp();
    for (int i = 0; i < 15; i++) mdl[i] = 64'd0;

    phase = "reset";
    cyc(); cyc();
    rst_n = 1'b1; w_dstE = 4'hF; w_dstM = 4'hF;
    for (int i = 0; i < 16; i++) peek(4'(i), (i == 15) ? 64'd0 : rst_tab[i]);

    phase = "opq";
    set_d(4'h6, 4'h0, 4'h3, 64'h10);
    cyc();
    chk("opq_valA", e_valA_a, 64'd111);
    chk("opq_valB", e_valB_a, 64'd444);
    chk("opq_dstE", e_dstE_a, 64'd3);
    chk("opq_dstM", e_dstM_a, 64'hF);

    phase = "bypass";
    w_dstE = 4'h0; w_valE = 64'd7;
    cyc();
    chk("byp_valA", e_valA_a, 64'd7);
    chk("nobyp_valA", e_valA_b, 64'd111);
    w_dstE = 4'hF;
    peek(4'h0, 64'd7);

    phase = "call";
    set_d(4'h8, 4'hF, 4'hF, 64'h40);
    cyc();
    chk("call_valA", e_valA_a, 64'h40);
    chk("call_valB", e_valB_a, 64'd555);
    chk("call_dstE", e_dstE_a, 64'd4);

    phase = "stall";
    stall = 1'b1;
    set_d(4'h6, 4'h1, 4'h2, 64'h99);
    w_dstE = 4'h1; w_valE = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      cyc();
      w_dstE = 4'hF;
      chk("stall_icode", e_icode_a, 64'h8);
      chk("stall_valA", e_valA_a, 64'h40);
    end
    peek(4'h1, 64'h1234);

    phase = "stall_bubble";
    bubble = 1'b1;
    cyc();
    chk("bub_valid", e_valid_a, 64'd0);
    chk("bub_icode", e_icode_a, 64'd1);
    stall = 1'b0; bubble = 1'b0;

    phase = "dual_write";
    set_d(4'hB, 4'h2, 4'hF, 64'h0);
    w_dstE = 4'h4; w_valE = 64'd547; w_dstM = 4'h4; w_valM = 64'd99;
    cyc();
    chk("popq_byp_valA", e_valA_a, 64'd99);
    chk("popq_nobyp_valA", e_valA_b, 64'd555);
    w_dstE = 4'hF; w_dstM = 4'hF;
    peek(4'h4, 64'd99);

    phase = "random";
    for (int n = 0; n < 60; n++) begin
      d_valid = 1'($urandom); d_icode = 4'($urandom_range(0, 11)); d_ifun = 4'($urandom);
      d_rA = 4'($urandom); d_rB = 4'($urandom);
      d_valC = {$urandom, $urandom}; d_valP = {$urandom, $urandom};
      w_dstE = 4'($urandom); w_dstM = 4'($urandom);
      w_valE = {$urandom, $urandom}; w_valM = {$urandom, $urandom};
      stall = ($urandom_range(0, 3) == 0); bubble = ($urandom_range(0, 7) == 0);
      cyc();
    end
    stall = 1'b0; bubble = 1'b0; w_dstM = 4'hF;

    phase = "mid_reset";
    set_d(4'h6, 4'h0, 4'h3, 64'h0);
    w_dstE = 4'h0; w_valE = 64'hDEAD;
    cyc();
    rst_n = 1'b0; w_valE = 64'hBEEF;
    cyc();
    chk("rst_valid", e_valid_a, 64'd0);
    rst_n = 1'b1; w_dstE = 4'hF;
    peek(4'h0, 64'd111);
    cyc();
    chk("post_rst_valA", e_valA_a, 64'd111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
